// File: rtl/player_pkg.sv
// Shared types and constants for player/entity motion controllers.
//   motion_state_t : IDLE/WALK/RISE/FALL (2-bit encoding, exported on `state`)
//   KEY_*          : USB HID keycodes used by the key decoder
//   vel_t          : 6-bit signed vertical velocity
package player_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WALK = 2'd1,
        RISE = 2'd2,
        FALL = 2'd3
    } motion_state_t;

    localparam logic [7:0] KEY_A     = 8'h04;
    localparam logic [7:0] KEY_D     = 8'h07;
    localparam logic [7:0] KEY_W     = 8'h1A;
    localparam logic [7:0] KEY_SPACE = 8'h2C;

    localparam int unsigned VEL_W = 6;
    typedef logic signed [VEL_W-1:0] vel_t;

    // True in the states where the player stands on the floor.
    function automatic logic is_grounded(input motion_state_t st);
        return (st == IDLE) || (st == WALK);
    endfunction

endpackage

// File: rtl/player_key_decode.sv
// Combinational map of two HID keycode slots to left/right/jump intents.
// Ports:
//   i_keycode0, i_keycode1 : HID keycodes (0x00 = none)
//   o_left_c   : A held in either slot
//   o_right_c  : D held in either slot
//   o_jump_c   : W or Space held in either slot
module player_key_decode
    import player_pkg::*;
(
    input  logic [7:0] i_keycode0,
    input  logic [7:0] i_keycode1,
    output logic       o_left_c,
    output logic       o_right_c,
    output logic       o_jump_c
);

    assign o_left_c  = (i_keycode0 == KEY_A) || (i_keycode1 == KEY_A);
    assign o_right_c = (i_keycode0 == KEY_D) || (i_keycode1 == KEY_D);
    assign o_jump_c  = (i_keycode0 == KEY_W)     || (i_keycode1 == KEY_W) ||
                       (i_keycode0 == KEY_SPACE) || (i_keycode1 == KEY_SPACE);

endmodule

// File: rtl/player_motion.sv
// Per-frame player kinematics: walk/jump intents from keycodes, 2-D position
// integration with gravity, evaluated once per frame_tick.
// Optional feature: define PLAYER_DOUBLE_JUMP_EN to allow one extra jump while
// airborne (re-armed on landing).
// Ports:
//   vga_clk      : clock
//   reset_n      : asynchronous active-low reset
//   frame_tick   : one-cycle update strobe per frame
//   keycode0/1   : HID keycodes, sampled only when frame_tick=1
//   BallX, BallY : registered sprite centre
//   facing_left  : registered, 1 selects mirrored sprite
//   state        : registered motion state (IDLE/WALK/RISE/FALL)
module player_motion
    import player_pkg::*;
#(
    parameter int unsigned X_START   = 320,
    parameter int unsigned Y_GROUND  = 400,
    parameter int unsigned X_MIN     = 15,
    parameter int unsigned X_MAX     = 624,
    parameter int unsigned Y_MIN     = 15,
    parameter int unsigned WALK_STEP = 2,
    parameter int unsigned JUMP_VEL  = 12,
    parameter int unsigned GRAVITY   = 1,
    parameter int unsigned VEL_MAX   = 12
)(
    input  logic       vga_clk,
    input  logic       reset_n,
    input  logic       frame_tick,
    input  logic [7:0] keycode0,
    input  logic [7:0] keycode1,
    output logic [9:0] BallX,
    output logic [9:0] BallY,
    output logic       facing_left,
    output logic [1:0] state
);

    localparam int unsigned POS_W = 10;
    localparam int unsigned ARI_W = 11;

    localparam logic signed [ARI_W-1:0] X_MIN_S    = ARI_W'(X_MIN);
    localparam logic signed [ARI_W-1:0] X_MAX_S    = ARI_W'(X_MAX);
    localparam logic signed [ARI_W-1:0] Y_MIN_S    = ARI_W'(Y_MIN);
    localparam logic signed [ARI_W-1:0] Y_GROUND_S = ARI_W'(Y_GROUND);
    localparam logic signed [ARI_W-1:0] STEP_S     = ARI_W'(WALK_STEP);
    localparam logic signed [VEL_W:0]   GRAV_S     = (VEL_W+1)'(GRAVITY);
    localparam logic signed [VEL_W:0]   VMAX_S     = (VEL_W+1)'(VEL_MAX);
    localparam vel_t                    VY_JUMP    = vel_t'(0 - int'(JUMP_VEL));

    logic [POS_W-1:0] r_x;
    logic [POS_W-1:0] r_y;
    vel_t             r_vy;
    motion_state_t    r_state;
    logic             r_facing;
    logic             r_prev_jump;
`ifdef PLAYER_DOUBLE_JUMP_EN
    logic             r_air_used;
    logic             w_air_used_nxt;
`endif

    logic                    w_left;
    logic                    w_right;
    logic                    w_jump;
    logic                    w_walk;
    logic                    w_jump_edge;
    logic signed [ARI_W-1:0] w_x_sum;
    logic signed [ARI_W-1:0] w_y_sum;
    logic signed [VEL_W:0]   w_vy_inc;
    logic [POS_W-1:0]        w_x_nxt;
    logic [POS_W-1:0]        w_y_nxt;
    vel_t                    w_vy_nxt;
    vel_t                    w_vy_grav;
    motion_state_t           w_state_nxt;
    logic                    w_facing_nxt;

    player_key_decode u_key_decode (
        .i_keycode0 (keycode0),
        .i_keycode1 (keycode1),
        .o_left_c   (w_left),
        .o_right_c  (w_right),
        .o_jump_c   (w_jump)
    );

    assign w_walk      = w_left ^ w_right;
    assign w_jump_edge = w_jump & ~r_prev_jump;

    // Horizontal step and clamp; 11-bit signed so the edges never wrap.
    always_comb begin
        w_x_sum      = $signed({1'b0, r_x});
        w_facing_nxt = r_facing;
        if (w_left && !w_right) begin
            w_x_sum      = $signed({1'b0, r_x}) - STEP_S;
            w_facing_nxt = 1'b1;
        end else if (w_right && !w_left) begin
            w_x_sum      = $signed({1'b0, r_x}) + STEP_S;
            w_facing_nxt = 1'b0;
        end
        if (w_x_sum < X_MIN_S) begin
            w_x_nxt = POS_W'(X_MIN);
        end else if (w_x_sum > X_MAX_S) begin
            w_x_nxt = POS_W'(X_MAX);
        end else begin
            w_x_nxt = w_x_sum[POS_W-1:0];
        end
    end

    // Candidate airborne integration: position step and capped gravity.
    always_comb begin
        w_y_sum   = $signed({1'b0, r_y}) + $signed({{(ARI_W-VEL_W){r_vy[VEL_W-1]}}, r_vy});
        w_vy_inc  = $signed({r_vy[VEL_W-1], r_vy}) + GRAV_S;
        w_vy_grav = (w_vy_inc > VMAX_S) ? VMAX_S[VEL_W-1:0] : w_vy_inc[VEL_W-1:0];
    end

    // Next-state and vertical update.
    always_comb begin
        w_state_nxt = r_state;
        w_y_nxt     = r_y;
        w_vy_nxt    = r_vy;
`ifdef PLAYER_DOUBLE_JUMP_EN
        w_air_used_nxt = r_air_used;
`endif
        if (is_grounded(r_state)) begin
            if (w_jump_edge) begin
                w_vy_nxt    = VY_JUMP;
                w_state_nxt = RISE;
            end else begin
                w_state_nxt = w_walk ? WALK : IDLE;
            end
        end
`ifdef PLAYER_DOUBLE_JUMP_EN
        else if (w_jump_edge && !r_air_used) begin
            w_vy_nxt       = VY_JUMP;
            w_state_nxt    = RISE;
            w_air_used_nxt = 1'b1;
        end
`endif
        else if (w_y_sum < Y_MIN_S) begin
            w_y_nxt     = POS_W'(Y_MIN);
            w_vy_nxt    = '0;
            w_state_nxt = FALL;
        end else if (w_y_sum >= Y_GROUND_S) begin
            w_y_nxt     = POS_W'(Y_GROUND);
            w_vy_nxt    = '0;
            w_state_nxt = w_walk ? WALK : IDLE;
`ifdef PLAYER_DOUBLE_JUMP_EN
            w_air_used_nxt = 1'b0;
`endif
        end else begin
            w_y_nxt     = w_y_sum[POS_W-1:0];
            w_vy_nxt    = w_vy_grav;
            w_state_nxt = (w_vy_grav >= 0) ? FALL : RISE;
        end
    end

    // State registers; everything holds between frame ticks.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_x         <= POS_W'(X_START);
            r_y         <= POS_W'(Y_GROUND);
            r_vy        <= '0;
            r_state     <= IDLE;
            r_facing    <= 1'b0;
            r_prev_jump <= 1'b0;
`ifdef PLAYER_DOUBLE_JUMP_EN
            r_air_used  <= 1'b0;
`endif
        end else if (frame_tick) begin
            r_x         <= w_x_nxt;
            r_y         <= w_y_nxt;
            r_vy        <= w_vy_nxt;
            r_state     <= w_state_nxt;
            r_facing    <= w_facing_nxt;
            r_prev_jump <= w_jump;
`ifdef PLAYER_DOUBLE_JUMP_EN
            r_air_used  <= w_air_used_nxt;
`endif
        end
    end

    assign BallX       = r_x;
    assign BallY       = r_y;
    assign facing_left = r_facing;
    assign state       = r_state;

endmodule

// File: doc/player_motion.md
# player_motion

Per-frame player kinematics controller sitting directly upstream of the player sprite renderers. It decodes keyboard keycodes into walk/jump intents and integrates a 2-D position with gravity on every frame tick. It drives the sprite centre (`BallX`/`BallY`) and a facing flag that selects between the normal and mirrored player sprite. All outputs are registered and stable for the whole active frame.

## Interface
- `X_START`, default 320: reset X centre.
- `Y_GROUND`, default 400: floor Y centre.
- `X_MIN` / `X_MAX`, defaults 15 / 624: horizontal clamp limits for the centre (30-px sprite).
- `Y_MIN`, default 15: ceiling clamp.
- `WALK_STEP`, default 2: pixels per frame.
- `JUMP_VEL`, default 12: initial upward speed.
- `GRAVITY`, default 1: per-frame velocity increment.
- `VEL_MAX`, default 12: downward speed cap.

Ports:
- `vga_clk`  in  1  sole clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `frame_tick`  in  1  one-cycle pulse per frame, at vsync.
- `keycode0`, `keycode1`  in  8 each  USB HID keycodes (0x00 = none).
- `BallX`, `BallY`  out  10 each  sprite centre.
- `facing_left`  out  1  1 selects the mirrored sprite.
- `state`  out  2  current motion state (for animation select).

## Operation
- Key decode uses either keycode slot: A=0x04 → left, D=0x07 → right, W=0x1A or Space=0x2C → jump.
- States: IDLE(0), WALK(1), RISE(2), FALL(3). All updates happen only in a cycle with `frame_tick`=1; all other cycles hold.
- Horizontal motion applies in every state:
  - Left only: X −= `WALK_STEP`, `facing_left`=1.
  - Right only: X += `WALK_STEP`, `facing_left`=0.
  - Both or neither: no move, facing unchanged.
  - Result is clamped to [`X_MIN`, `X_MAX`]. Compute in 11-bit signed before clamping, so no wrap at 0 or 1023.
- Grounded (IDLE/WALK):
  - Jump rising edge (jump now and not at the previous tick): vy = −`JUMP_VEL`, Y unchanged, go to RISE.
  - Otherwise go to WALK if a single direction is pressed, else IDLE.
  - Holding jump never re-triggers.
- Airborne (RISE/FALL), each tick:
  - Y += vy, then vy = min(vy + `GRAVITY`, `VEL_MAX`).
  - RISE→FALL when the updated vy ≥ 0.
  - Ceiling: if Y + vy < `Y_MIN`, then Y = `Y_MIN`, vy = 0, go to FALL.
  - Landing: if Y + vy ≥ `Y_GROUND`, then Y = `Y_GROUND`, vy = 0, go to IDLE/WALK per horizontal keys.
- Velocity is a 6-bit signed register. Y arithmetic is 11-bit signed.
- Previous-jump flag is updated on every tick.

## Timing
- Reset values: `BallX`=`X_START`, `BallY`=`Y_GROUND`, `facing_left`=0, `state`=IDLE, vy=0, previous-jump=0, air-jump-used=0.
- Keycodes are sampled in the `frame_tick` cycle. New outputs are visible on the next `vga_clk` edge (latency 1).
- Keycode changes between ticks are ignored.
- `frame_tick` on consecutive cycles is legal; each pulse is one full update.
- Reset asserted mid-jump returns immediately to the reset values. The first tick after release is treated as the previous-jump=0 baseline.

## Configuration
- `PLAYER_DOUBLE_JUMP_EN`:
  - Defined: while in RISE/FALL with air-jump-used=0, a jump rising edge sets vy = −`JUMP_VEL`, state = RISE, air-jump-used=1. Landing clears air-jump-used.
  - Undefined: air-jump-used logic is absent and jump edges while airborne are ignored.

## Structure
- `player_pkg` holds:
  - the `motion_state_t` enum (IDLE/WALK/RISE/FALL),
  - keycode constants `KEY_A`, `KEY_D`, `KEY_W`, `KEY_SPACE`,
  - the `vel_t` (6-bit signed) typedef.
- One sub-module, `player_key_decode`: combinational map of the two keycodes to left/right/jump. It is reused by any later entity controller.

## Test plan
- Reset: assert `reset_n`=0 mid-frame → outputs 320/400/0/IDLE asynchronously. Tick with no keys → unchanged.
- Walk: D held for 10 ticks → `BallX`=340, `state`=WALK, `facing_left`=0. A and D together → X frozen, facing unchanged.
- Wall clamp: start X=17, A held 3 ticks → 15, 15, 15. No wrap.
- Jump arc: W pressed at one tick then held → RISE with Y=400.
  - After 12 airborne ticks: Y=322, state FALL.
  - Continues to land: Y=400, vy=0, IDLE.
  - Held W never re-jumps.
- Ticks only: keys toggled between ticks without `frame_tick` → no output change.
- Double jump: with macro defined, second W edge at apex → vy=−12 again. A third edge is ignored. Without the macro the second edge is ignored.
